// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage-control bundle order: five write enables, then three bubble selects.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {ST_RUN = 1'b0, ST_MULT = 1'b1} state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_OFF    = 8'b0000_0000;
  localparam stage_ctl_t CTL_RUN    = 8'b1111_1000;
  localparam stage_ctl_t CTL_BRANCH = 8'b1111_1110;
  // Younger stages hold, EX/MEM takes a bubble, MEM/WB drains.
  localparam stage_ctl_t CTL_MULT   = 8'b0000_1001;
  localparam stage_ctl_t CTL_LU     = 8'b0011_1010;

endpackage

// File: rtl/pipe_hazard_ctrl_lu.sv
// Load-use comparator: flags an ID instruction that reads the register
// a load in EX is about to write.
module lu_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       i_memread,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rt,
  output logic       o_lu
);

  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign o_lu = i_memread && (i_rd != REG_ZERO) &&
                ((i_rd == i_rs) || (i_uses_rt && (i_rd == i_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-register control: write enables and bubble selects for load-use
// stalls, multi-cycle EX ops and taken branches, plus a stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_mult_start,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MCNT_W = $clog2(MULT_LAT);
  // mcnt holds the number of MULT-state cycles still to go.
  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MULT_LAT - 2);
  localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);
  localparam logic              MULT_WAIT = (MULT_LAT > 2);

  state_e            r_state, w_state_nxt;
  logic [MCNT_W-1:0] r_mcnt, w_mcnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu;
  stage_ctl_t        w_ctl;

  lu_hazard_cmp u_lu (
    .i_memread (idex_memread),
    .i_rd      (idex_rd),
    .i_rs      (id_rs),
    .i_rt      (id_rt),
    .i_uses_rt (id_uses_rt),
    .o_lu      (w_lu)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= ST_RUN;
      r_mcnt      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
      if (!w_ctl.pc_we) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    if (r_state == ST_RUN) begin
      // A 2-cycle op is fully covered by its single RUN stall cycle.
      if (!ex_branch_taken && ex_mult_start && MULT_WAIT) begin
        w_state_nxt = ST_MULT;
        w_mcnt_nxt  = MCNT_LOAD;
      end
    end else begin
      w_mcnt_nxt = r_mcnt - MCNT_ONE;
      if (r_mcnt <= MCNT_ONE) w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    w_ctl = CTL_OFF;
    if (!areset) begin
      if (r_state == ST_MULT) w_ctl = CTL_MULT;
      else if (ex_branch_taken) w_ctl = CTL_BRANCH;
      else if (ex_mult_start)   w_ctl = CTL_MULT;
      else if (w_lu)            w_ctl = CTL_LU;
      else                      w_ctl = CTL_RUN;
    end
  end

  assign pc_we       = w_ctl.pc_we;
  assign ifid_we     = w_ctl.ifid_we;
  assign idex_we     = w_ctl.idex_we;
  assign exmem_we    = w_ctl.exmem_we;
  assign memwb_we    = w_ctl.memwb_we;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_flush = w_ctl.exmem_flush;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int MULT_LAT = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, idex_rd = '0;
  logic             id_uses_rt = 1'b0, idex_memread = 1'b0;
  logic             ex_mult_start = 1'b0, ex_branch_taken = 1'b0;
  logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_left = 0;   // remaining forced-stall cycles of a multi-cycle op
  int m_cnt  = 0;   // expected stall counter

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .areset(areset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ex_mult_start(ex_mult_start), .ex_branch_taken(ex_branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_cnt(stall_cnt)
  );

  // Order: pc, ifid, idex, exmem, memwb we; ifid, idex, exmem flush.
  function automatic logic [7:0] ref_out(input logic br, ms, mr,
                                         input logic [4:0] rd, rs, rt,
                                         input logic urt);
    logic lu;
    lu = mr && (rd != 0) && ((rd == rs) || (urt && (rd == rt)));
    if (m_left > 0) return 8'b0000_1001;
    if (br)         return 8'b1111_1110;
    if (ms)         return 8'b0000_1001;
    if (lu)         return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  function automatic logic [7:0] dut_out();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
            ifid_flush, idex_flush, exmem_flush};
  endfunction

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic cyc(input logic br, ms, mr, input logic [4:0] rd, rs, rt,
                     input logic urt, output logic [7:0] got, output logic [7:0] exp,
                     output int gcnt, output int ecnt);
    ex_branch_taken = br; ex_mult_start = ms; idex_memread = mr;
    idex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    #3;
    exp  = ref_out(br, ms, mr, rd, rs, rt, urt);
    got  = dut_out();
    gcnt = int'(stall_cnt);
    ecnt = m_cnt;
    @(posedge clk);
    if (!exp[7]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (m_left > 0) m_left--;
    else if (!br && ms) m_left = MULT_LAT - 2;
    #1;
  endtask

  task automatic do_reset();
    #1 areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    m_left = 0;
    m_cnt  = 0;
  endtask

  task automatic test_reset();
    logic [7:0] g, e; int gc, ec;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    m_left = 0; m_cnt = 0;
    cyc(0,0,1,5'd5,5'd5,5'd0,0,g,e,gc,ec);
    cyc(0,1,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    #1 areset = 1'b1;
    #1;
    n_cmp++;
    if (dut_out() !== 8'h00) begin
      n_err++; $display("FAIL reset_outs got=%b exp=%b", dut_out(), 8'h00);
    end
    n_cmp++;
    if (stall_cnt !== '0) begin
      n_err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    @(posedge clk);
    #1 areset = 1'b0;
    m_left = 0; m_cnt = 0;
    cyc(0,0,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    n_cmp++;
    if (g !== 8'b1111_1000) begin
      n_err++; $display("FAIL reset_release got=%b exp=%b", g, 8'b1111_1000);
    end
  endtask

  task automatic test_load_use();
    logic [7:0] g, e; int gc, ec;
    logic [4:0] rd_t[6] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0};
    logic [4:0] rs_t[6] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] rt_t[6] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0};
    logic       ur_t[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       mr_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      cyc(0,0,mr_t[i],rd_t[i],rs_t[i],rt_t[i],ur_t[i],g,e,gc,ec);
      n_cmp++;
      if (g !== e) begin
        n_err++; $display("FAIL lu_outs[%0d] got=%b exp=%b", i, g, e);
      end
      n_cmp++;
      if (gc !== ec) begin
        n_err++; $display("FAIL lu_cnt[%0d] got=%0d exp=%0d", i, gc, ec);
      end
    end
  endtask

  task automatic test_mult();
    logic [7:0] g, e; int gc, ec, c0, stalls;
    stalls = 0;
    c0 = m_cnt;
    for (int i = 0; i < 5; i++) begin
      cyc(0, (i == 0), 0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
      if (!g[7]) stalls++;
      n_cmp++;
      if (g !== e) begin
        n_err++; $display("FAIL mult_outs[%0d] got=%b exp=%b", i, g, e);
      end
    end
    n_cmp++;
    if (stalls !== MULT_LAT - 1) begin
      n_err++; $display("FAIL mult_len got=%0d exp=%0d", stalls, MULT_LAT - 1);
    end
    n_cmp++;
    if (gc !== (c0 + MULT_LAT - 1) % (1 << CNT_W)) begin
      n_err++; $display("FAIL mult_cnt got=%0d exp=%0d", gc, (c0 + MULT_LAT - 1) % (1 << CNT_W));
    end
    // Load-use hazard waiting behind the op stalls one extra cycle.
    cyc(0,1,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    cyc(1,0,1,5'd3,5'd3,5'd0,0,g,e,gc,ec);
    cyc(1,0,1,5'd3,5'd3,5'd0,0,g,e,gc,ec);
    cyc(0,0,1,5'd3,5'd3,5'd0,0,g,e,gc,ec);
    n_cmp++;
    if (g !== 8'b0011_1010) begin
      n_err++; $display("FAIL mult_then_lu got=%b exp=%b", g, 8'b0011_1010);
    end
  endtask

  task automatic test_branch_hazard();
    logic [7:0] g, e; int gc, ec, c0;
    c0 = m_cnt;
    cyc(1,0,1,5'd5,5'd5,5'd0,0,g,e,gc,ec);
    n_cmp++;
    if (g !== 8'b1111_1110) begin
      n_err++; $display("FAIL br_outs got=%b exp=%b", g, 8'b1111_1110);
    end
    cyc(0,0,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    n_cmp++;
    if (gc !== c0) begin
      n_err++; $display("FAIL br_cnt got=%0d exp=%0d", gc, c0);
    end
  endtask

  task automatic test_wrap_abort();
    logic [7:0] g, e; int gc, ec, stalls;
    do_reset();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 3; i++) cyc(0,(i == 0),0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    cyc(0,0,1,5'd2,5'd2,5'd0,0,g,e,gc,ec);
    cyc(0,0,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    n_cmp++;
    if (gc !== 0 || ec !== 0) begin
      n_err++; $display("FAIL wrap_cnt got=%0d exp=0", gc);
    end
    cyc(0,1,0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
    #1 areset = 1'b1;
    #1;
    n_cmp++;
    if (dut_out() !== 8'h00) begin
      n_err++; $display("FAIL abort_outs got=%b exp=%b", dut_out(), 8'h00);
    end
    @(posedge clk);
    #1 areset = 1'b0;
    m_left = 0; m_cnt = 0;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0,(i == 0),0,5'd0,5'd0,5'd0,0,g,e,gc,ec);
      if (!g[7]) stalls++;
    end
    n_cmp++;
    if (stalls !== MULT_LAT - 1) begin
      n_err++; $display("FAIL abort_restall got=%0d exp=%0d", stalls, MULT_LAT - 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e; int gc, ec;
    logic br, ms, mr, ur;
    logic [4:0] rd, rs, rt;
    for (int i = 0; i < 400; i++) begin
      br = ($urandom_range(7) == 0);
      ms = ($urandom_range(9) == 0);
      mr = 1'($urandom_range(1));
      ur = 1'($urandom_range(1));
      rd = 5'($urandom_range(3));
      rs = 5'($urandom_range(3));
      rt = 5'($urandom_range(3));
      cyc(br,ms,mr,rd,rs,rt,ur,g,e,gc,ec);
      n_cmp++;
      if (g !== e) begin
        n_err++; $display("FAIL rand_outs[%0d] got=%b exp=%b", i, g, e);
      end
      n_cmp++;
      if (gc !== ec) begin
        n_err++; $display("FAIL rand_cnt[%0d] got=%0d exp=%0d", i, gc, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mult();
    test_branch_hazard();
    test_wrap_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
